// File: rtl/ram2p_fifo_ctrl_pkg.sv
// Shared widths and elaboration helpers for the ram2p FIFO controller.
package ram2p_pkg;

    localparam int unsigned AWID_DEF = 8;
    localparam int unsigned DWID_DEF = 16;

    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_FULL  = 2'd2
    } obuf_lvl_e;

    function automatic int unsigned ptr_w(input int unsigned awid);
        return awid + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned awid);
        return awid + 2;
    endfunction

    function automatic bit depth_ok(input int unsigned awid, input int unsigned depth);
        return depth == (32'd1 << awid);
    endfunction

endpackage

// File: rtl/ram2p_fifo_obuf.sv
// Two-entry registered output buffer; entry 0 is always the head word.
module ram2p_fifo_obuf
    import ram2p_pkg::*;
#(
    parameter int unsigned DWID = DWID_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [DWID-1:0] i_dat,
    output logic [DWID-1:0] o_dat,
    output logic            o_valid,
    output logic [1:0]      o_cnt
);

    obuf_lvl_e       lvl_q, lvl_d;
    logic [DWID-1:0] e0_q, e0_d, e1_q, e1_d;

    always_comb begin
        lvl_d = lvl_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case (lvl_q)
            OB_EMPTY: begin
                if (i_push) begin
                    e0_d  = i_dat;
                    lvl_d = OB_ONE;
                end
            end
            OB_ONE: begin
                case ({i_push, i_pop})
                    2'b10:   begin e1_d = i_dat; lvl_d = OB_FULL; end
                    2'b01:   lvl_d = OB_EMPTY;
                    2'b11:   e0_d = i_dat;
                    default: ;
                endcase
            end
            OB_FULL: begin
                // the controller never pushes into a full buffer without popping
                if (i_pop) begin
                    e0_d = e1_q;
                    if (i_push) e1_d = i_dat;
                    else        lvl_d = OB_ONE;
                end
            end
            default: lvl_d = OB_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl_q <= OB_EMPTY;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            lvl_q <= lvl_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign o_dat   = e0_q;
    assign o_valid = (lvl_q != OB_EMPTY);
    assign o_cnt   = lvl_q;

endmodule

// File: rtl/ram2p_fifo_ctrl.sv
// Ready/valid FIFO controller driving an external ram2p; reads are issued ahead into a 2-entry buffer.
// Optional RAM2P_FIFO_HIWATER_EN adds o_hiwater, the peak o_count since reset.
module ram2p_fifo_ctrl
    import ram2p_pkg::*;
#(
    parameter int unsigned AWID  = AWID_DEF,
    parameter int unsigned DEPTH = 2**AWID,
    parameter int unsigned DWID  = DWID_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_wvalid,
    output logic            o_wready,
    input  logic [DWID-1:0] i_wdat,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [DWID-1:0] o_rdat,
    output logic            o_ram_we,
    output logic [AWID-1:0] o_ram_waddr,
    output logic [DWID-1:0] o_ram_wdat,
    output logic [AWID-1:0] o_ram_raddr,
    input  logic [DWID-1:0] i_ram_rdat,
    output logic [AWID+1:0] o_count,
    output logic            o_empty
`ifdef RAM2P_FIFO_HIWATER_EN
   ,output logic [AWID+1:0] o_hiwater
`endif
);

    localparam int unsigned PW = ptr_w(AWID);
    localparam int unsigned CW = cnt_w(AWID);

    if (!depth_ok(AWID, DEPTH)) begin : g_depth_chk
        $error("ram2p_fifo_ctrl: DEPTH must equal 2**AWID");
    end

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, ram_cnt;
    logic          inflight_q, inflight_d;
    logic [1:0]    obuf_cnt;
    logic          wacc, pop, issue, rvalid;

    always_comb begin
        ram_cnt  = wptr_q - rptr_q;
        o_wready = (ram_cnt != PW'(DEPTH));
        wacc     = i_wvalid & o_wready;
        pop      = rvalid & i_rready;
        // keep buffered + in-flight words at most 2 after this edge
        issue    = (ram_cnt != '0) &&
                   (({1'b0, obuf_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
        wptr_d     = wptr_q + PW'(wacc);
        rptr_d     = rptr_q + PW'(issue);
        inflight_d = issue;

        o_ram_we    = wacc & rstn;
        o_ram_waddr = wptr_q[AWID-1:0];
        o_ram_wdat  = i_wdat;
        o_ram_raddr = rptr_q[AWID-1:0];
        o_rvalid    = rvalid;
        o_count     = CW'(ram_cnt) + CW'(inflight_q) + CW'(obuf_cnt);
        o_empty     = (o_count == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
        end
    end

    ram2p_fifo_obuf #(.DWID(DWID)) u_obuf (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (inflight_q),
        .i_pop   (pop),
        .i_dat   (i_ram_rdat),
        .o_dat   (o_rdat),
        .o_valid (rvalid),
        .o_cnt   (obuf_cnt)
    );

`ifdef RAM2P_FIFO_HIWATER_EN
    logic [CW-1:0] hiw_q, hiw_d, cnt_nxt;

    // next o_count: issue moves a word RAM->in-flight, landing moves it in-flight->buffer
    always_comb begin
        cnt_nxt = o_count + CW'(wacc) - CW'(pop);
        hiw_d   = (cnt_nxt > hiw_q) ? cnt_nxt : hiw_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) hiw_q <= '0;
        else       hiw_q <= hiw_d;
    end

    assign o_hiwater = hiw_q;
`endif

endmodule
